// File: rtl/bmult_prod_accum.sv
// -----------------------------------------------------------------------------
// bmult_prod_accum
//
// Product accumulator that sits downstream of a registered-input 14x14
// multiplier.  It issues the operand-accept strobe (in_ready) for the
// multiplier, tracks which products are meaningful with a fixed-latency
// {valid,last} tag pipeline, sums every ACC_LEN tagged products and presents
// the group sum on a valid/ready output.  The multiplier itself never stalls,
// so issue is throttled instead: the last element of a group is only accepted
// when the previous group's sum has been (or is being) handed off.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream presents an operand pair this cycle
//   in_ready   : pair accepted when in_valid && in_ready at the edge
//   flush      : synchronous clear of all group state
//   P          : product from the multiplier stage
//   out_valid  : sum holds a completed group
//   out_ready  : downstream accepts sum
//   sum        : group sum, held stable while out_valid && !out_ready
//   group_cnt  : number of groups handed off downstream (wraps)
// -----------------------------------------------------------------------------
module bmult_prod_accum #(
  parameter int P_W        = 28,
  parameter int PIPE_DEPTH = 2,
  parameter int ACC_LEN    = 8,
  parameter int ACC_W      = P_W + $clog2(ACC_LEN),
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [P_W-1:0]   P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] group_cnt
);

  localparam int               IDX_W    = $clog2(ACC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_LEN - 1);

  logic [IDX_W-1:0]      issue_cnt;
  logic [PIPE_DEPTH-1:0] tag_valid;
  logic [PIPE_DEPTH-1:0] tag_last;
  logic                  slot_busy;
  logic [ACC_W-1:0]      acc;

  logic             handshake;
  logic             accept;
  logic             last_accept;
  logic             p_valid;
  logic             p_last;
  logic [ACC_W-1:0] acc_plus_p;

  assign handshake   = out_valid && out_ready;

  // The last element of a group may only enter when the output slot is free,
  // or is being freed by a handshake on this very edge.  Depends only on
  // registers and out_ready, never on in_valid.
  assign in_ready    = !(issue_cnt == LAST_IDX && slot_busy && !handshake);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (issue_cnt == LAST_IDX);

  // The oldest tag lines up with the product currently on P.
  assign p_valid     = tag_valid[PIPE_DEPTH-1];
  assign p_last      = tag_last[PIPE_DEPTH-1];
  assign acc_plus_p  = acc + ACC_W'(P);

  // Issue side: element index, tag pipeline and output-slot reservation.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      tag_valid <= '0;
      tag_last  <= '0;
      slot_busy <= 1'b0;
    end else if (flush) begin
      // Drops in-flight products and any accept in this cycle.
      issue_cnt <= '0;
      tag_valid <= '0;
      tag_last  <= '0;
      slot_busy <= 1'b0;
    end else begin
      tag_valid[0] <= accept;
      tag_last[0]  <= last_accept;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end

      if (accept) begin
        issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 1'b1;
      end

      // A new reservation wins over the release of the previous one.
      if (last_accept) begin
        slot_busy <= 1'b1;
      end else if (handshake) begin
        slot_busy <= 1'b0;
      end
    end
  end

  // Accumulate side: running sum, completed-group register and handoff count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      group_cnt <= '0;
    end else if (flush) begin
      // sum and group_cnt intentionally keep their values.
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (handshake) begin
        out_valid <= 1'b0;
        group_cnt <= group_cnt + 1'b1;
      end

      // Placed after the handshake so a completion on the same edge keeps
      // out_valid high for the new sum.
      if (p_valid) begin
        if (p_last) begin
          sum       <= acc_plus_p;
          out_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc       <= acc_plus_p;
        end
      end
    end
  end

endmodule
